// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/busy/done handshake, registered result
// and flags, a shift-add multiplier and an optional restoring divider.
// Optional feature macro: ALU_SEQ_DIV_EN (defined = divider built, opcode 9 = DIV).
module alu_seq #(
   parameter int LENGTH_v = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  start,
   input  logic [LENGTH_v-1:0]   A,
   input  logic [LENGTH_v-1:0]   B,
   input  logic [3:0]            control,
   output logic                  busy,
   output logic                  done,
   output logic [2*LENGTH_v-1:0] result,
   output logic                  carry,
   output logic                  overflow,
   output logic                  negative,
   output logic                  zero,
   output logic                  div_by_zero
);

   localparam int L  = LENGTH_v;
   localparam int SW = $clog2(L);
   localparam int CW = $clog2(L);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;

   // ONE is the common write-back state: single-cycle ops go straight there,
   // MUL/DIV pass through EXEC first, which gives the extra cycle of latency.
   typedef enum logic [1:0] {S_IDLE, S_ONE, S_EXEC} state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       cnt_reg;
   logic [L-1:0]        a_reg, b_reg;
   logic [3:0]          op_reg;
   logic [2*L-1:0]      work_reg;
   logic                is_seq;

   logic [L:0]          mul_sum;
   logic [2*L:0]        mul_cat;
   logic [2*L-1:0]      mul_step;
   logic [2*L-1:0]      div_step;

   logic [L-1:0]        and_v, or_v, xor_v, not_v;
   logic [L:0]          sum_ext, diff_ext;
   logic [L-1:0]        lo_res;
   logic [2*L-1:0]      wide_res, res_next;
   logic                use_wide, carry_next, ovf_next, dbz_next;

   assign busy = (state_reg == S_EXEC);

`ifdef ALU_SEQ_DIV_EN
   assign is_seq = (control == OP_MUL) || ((control == OP_DIV) && (B != '0));
`else
   assign is_seq = (control == OP_MUL);
`endif

   // Next-state selection; enable gating is applied in the state register.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = is_seq ? S_EXEC : S_ONE;
         S_ONE:   state_next = S_IDLE;
         S_EXEC:  if (cnt_reg == CW'(L-1)) state_next = S_ONE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register, frozen while enable is low.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       state_reg <= S_IDLE;
      else if (enable) state_reg <= state_next;
   end

   // One multiplier step: conditionally add A into the upper half, shift right.
   always_comb begin
      mul_sum  = {1'b0, work_reg[2*L-1:L]} + (work_reg[0] ? {1'b0, a_reg} : '0);
      mul_cat  = {mul_sum, work_reg[L-1:0]};
      mul_step = mul_cat[2*L:1];
   end

`ifdef ALU_SEQ_DIV_EN
   logic [L:0]   div_shift, div_diff;
   logic         div_ge;
   // One restoring-divide step on {remainder, quotient}.
   always_comb begin
      div_shift = {work_reg[2*L-1:L], work_reg[L-1]};
      div_diff  = div_shift - {1'b0, b_reg};
      div_ge    = (div_shift >= {1'b0, b_reg});
      div_step  = {(div_ge ? div_diff[L-1:0] : div_shift[L-1:0]),
                   work_reg[L-2:0], div_ge};
   end
`else
   assign div_step = '0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_logic
         assign and_v[gi] = a_reg[gi] & b_reg[gi];
         assign or_v[gi]  = a_reg[gi] | b_reg[gi];
         assign xor_v[gi] = a_reg[gi] ^ b_reg[gi];
         assign not_v[gi] = ~a_reg[gi];
      end
   endgenerate

   // Result and flag values written back in ONE.
   always_comb begin
      sum_ext    = {1'b0, a_reg} + {1'b0, b_reg};
      diff_ext   = {1'b0, a_reg} - {1'b0, b_reg};
      lo_res     = '0;
      wide_res   = '0;
      use_wide   = 1'b0;
      carry_next = 1'b0;
      ovf_next   = 1'b0;
      dbz_next   = 1'b0;
      case (op_reg)
         OP_ADD: begin
            lo_res     = sum_ext[L-1:0];
            carry_next = sum_ext[L];
            ovf_next   = (a_reg[L-1] == b_reg[L-1]) && (sum_ext[L-1] != a_reg[L-1]);
         end
         OP_SUB: begin
            lo_res     = diff_ext[L-1:0];
            carry_next = diff_ext[L];
            ovf_next   = (a_reg[L-1] != b_reg[L-1]) && (diff_ext[L-1] != a_reg[L-1]);
         end
         OP_AND: lo_res = and_v;
         OP_OR:  lo_res = or_v;
         OP_XOR: lo_res = xor_v;
         OP_NOT: lo_res = not_v;
         OP_SHL: lo_res = a_reg << b_reg[SW-1:0];
         OP_SHR: lo_res = a_reg >> b_reg[SW-1:0];
         OP_MUL: begin
            use_wide = 1'b1;
            wide_res = work_reg;
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            use_wide = 1'b1;
            if (b_reg == '0) begin
               wide_res = {a_reg, {L{1'b1}}};
               dbz_next = 1'b1;
            end else begin
               wide_res = work_reg;
            end
         end
`endif
         default: ;
      endcase
      res_next = use_wide ? wide_res : {{L{1'b0}}, lo_res};
   end

   // Operand capture, sequential unit iteration and registered write-back.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg     <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         op_reg      <= '0;
         work_reg    <= '0;
         done        <= 1'b0;
         result      <= '0;
         carry       <= 1'b0;
         overflow    <= 1'b0;
         negative    <= 1'b0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (enable) begin
         case (state_reg)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg    <= A;
                  b_reg    <= B;
                  op_reg   <= control;
                  cnt_reg  <= '0;
                  work_reg <= (control == OP_MUL) ? {{L{1'b0}}, B} : {{L{1'b0}}, A};
               end
            end
            S_EXEC: begin
               done     <= 1'b0;
               work_reg <= (op_reg == OP_DIV) ? div_step : mul_step;
               cnt_reg  <= (cnt_reg == CW'(L-1)) ? '0 : cnt_reg + 1'b1;
            end
            S_ONE: begin
               done        <= 1'b1;
               result      <= res_next;
               carry       <= carry_next;
               overflow    <= ovf_next;
               negative    <= use_wide ? res_next[2*L-1] : res_next[L-1];
               zero        <= (res_next == '0);
               div_by_zero <= dbz_next;
            end
            default: done <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (LENGTH_v = 5).
module tb_alu_seq;

   localparam int L = 5;
   localparam int W = 2 * L;

   logic          clock = 1'b0;
   logic          reset, enable, start;
   logic [L-1:0]  A, B;
   logic [3:0]    control;
   logic          busy, done, carry, overflow, negative, zero, div_by_zero;
   logic [W-1:0]  result;

   alu_seq #(.LENGTH_v(L)) dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .A(A), .B(B), .control(control),
      .busy(busy), .done(done), .result(result),
      .carry(carry), .overflow(overflow), .negative(negative),
      .zero(zero), .div_by_zero(div_by_zero)
   );

   always #5 clock = ~clock;

   typedef struct {
      string tag;
      int    res;
      bit    c, v, n, z, dbz;
      int    lat;
      int    busyc;
   } exp_t;

   exp_t sbq[$];
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int sx(input int x);
      return (x >= 16) ? x - 32 : x;
   endfunction

   function automatic exp_t model(input string tag, input int op, input int a, input int b);
      exp_t e;
      int   s;
      e.tag = tag; e.res = 0; e.c = 0; e.v = 0; e.dbz = 0; e.lat = 1; e.busyc = 0;
      case (op)
         0: begin
            s = a + b; e.res = s % 32; e.c = (s >= 32);
            s = sx(a) + sx(b); e.v = (s > 15) || (s < -16);
         end
         1: begin
            e.res = (a - b + 32) % 32; e.c = (a < b);
            s = sx(a) - sx(b); e.v = (s > 15) || (s < -16);
         end
         2: e.res = a & b;
         3: e.res = a | b;
         4: e.res = a ^ b;
         5: e.res = (~a) & 31;
         6: e.res = (a << (b % 8)) % 32;
         7: e.res = a >> (b % 8);
         8: begin e.res = a * b; e.lat = L + 1; e.busyc = L; end
`ifdef ALU_SEQ_DIV_EN
         9: begin
            if (b == 0) begin
               e.res = a * 32 + 31; e.dbz = 1;
            end else begin
               e.res = (a % b) * 32 + a / b; e.lat = L + 1; e.busyc = L;
            end
         end
`endif
         default: e.res = 0;
      endcase
      if (op <= 7)      e.n = ((e.res >> (L - 1)) & 1) != 0;
      else if (op <= 9) e.n = ((e.res >> (W - 1)) & 1) != 0;
      else              e.n = 0;
      e.z = (e.res == 0);
      return e;
   endfunction

   // Launch one op, wait for done (bounded), then compare against the scoreboard.
   task automatic run_op(input string tag, input int op, input int a, input int b,
                         input int poke, input int freeze);
      exp_t e, got;
      int   cycles, busy_cnt;
      bit   seen;
      @(negedge clock);
      A = L'(a); B = L'(b); control = 4'(op); start = 1'b1;
      e = model(tag, op, a, b);
      e.lat   += freeze;
      e.busyc += freeze;
      sbq.push_back(e);
      @(negedge clock);
      start = 1'b0;
      A = A ^ 5'h1F; B = B ^ 5'h15;
      busy_cnt = busy ? 1 : 0;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 40) begin
         if (poke != 0 && cycles == 1) begin start = 1'b1; control = 4'd0; end
         if (poke != 0 && cycles == 2) start = 1'b0;
         if (freeze != 0 && cycles == 2) enable = 1'b0;
         if (freeze != 0 && cycles == 2 + freeze) enable = 1'b1;
         @(negedge clock);
         cycles++;
         if (done) seen = 1'b1;
         else if (busy) busy_cnt++;
      end
      enable = 1'b1;
      start  = 1'b0;
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      got = sbq.pop_front();
      check({tag, " latency"}, 32'(cycles), 32'(got.lat));
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(got.busyc));
      check({tag, " result"}, 32'(result), 32'(got.res));
      check({tag, " flags"}, {27'd0, carry, overflow, negative, zero, div_by_zero},
            {27'd0, got.c, got.v, got.n, got.z, got.dbz});
      $display("op %s: A=%0d B=%0d result=%0d lat=%0d busy=%0d", tag, a, b, result, cycles, busy_cnt);
      @(negedge clock);
      check({tag, " hold_result"}, 32'(result), 32'(got.res));
      check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int done_cnt;
      reset = 1'b1; enable = 1'b1; start = 1'b0;
      A = '0; B = '0; control = '0;
      #1;
      check("reset_state", {20'd0, busy, done, result, carry, overflow, negative, zero, div_by_zero}, 32'd0);
      $display("reset: busy=%0b done=%0b result=%0d", busy, done, result);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      run_op("add_15_17", 0, 15, 17, 0, 0);
      run_op("add_15_1",  0, 15, 1,  0, 0);
      run_op("sub_3_5",   1, 3,  5,  0, 0);
      run_op("sub_20_7",  1, 20, 7,  0, 0);
      run_op("and",       2, 26, 15, 0, 0);
      run_op("or",        3, 18, 5,  0, 0);
      run_op("xor",       4, 27, 9,  0, 0);
      run_op("not",       5, 10, 0,  0, 0);
      run_op("shl_3_2",   6, 3,  2,  0, 0);
      run_op("shl_1_6",   6, 1,  6,  0, 0);
      run_op("shl_5_9",   6, 5,  9,  0, 0);
      run_op("shr_31_3",  7, 31, 3,  0, 0);
      run_op("mul_31_31", 8, 31, 31, 1, 0);
      run_op("mul_0_22",  8, 0,  22, 0, 0);
      run_op("mul_frz",   8, 13, 11, 0, 2);
      run_op("div_29_4",  9, 29, 4,  0, 0);
      run_op("div_9_0",   9, 9,  0,  0, 0);
      run_op("div_31_1",  9, 31, 1,  0, 0);
      run_op("unused_12", 12, 5, 3,  0, 0);
      run_op("mul_25_19", 8, 25, 19, 0, 0);

      // Reset during the third cycle of a MUL: outputs clear at once, no done.
      @(negedge clock);
      A = 5'd7; B = 5'd9; control = 4'd8; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_reset_outputs", {20'd0, busy, done, result, carry, overflow, negative, zero, div_by_zero}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (done || busy) done_cnt++;
      end
      check("mid_reset_no_done", 32'(done_cnt), 32'd0);
      $display("reset mid-MUL: result=%0d stray_done_or_busy=%0d", result, done_cnt);

      run_op("add_after_rst", 0, 9, 4, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
